// File: rtl/n_bit_mux_sel_pipe.sv
// M-input N-bit select mux for register-file writeback.
// Registered output with one-entry skid buffer and illegal-select counter.
module n_bit_mux_sel_pipe #(
  parameter int N     = 32,
  parameter int M     = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M*N-1:0]   in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sel_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int               SEL_N   = 2**SEL_W;
  localparam logic [SEL_W:0]   M_W     = (SEL_W+1)'(M);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t         state_q;
  state_t         state_d;
  logic           main_v;
  logic           skid_v;
  logic [N-1:0]   main_d;
  logic [N-1:0]   skid_d;
  logic           main_e;
  logic           skid_e;
  logic [N-1:0]   sel_val;
  logic           sel_err;
  logic           in_fire;
  logic           out_fire;
  logic           ld_main_in;
  logic           ld_main_skid;
  logic           ld_skid;

  // Select resolution: out-of-range codes yield zero and raise sel_err.
  always_comb begin
    sel_val = '0;
    sel_err = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (in_sel == SEL_W'(k)) sel_val = in_data[k*N +: N];
    end
    if (M < SEL_N) sel_err = ({1'b0, in_sel} >= M_W);
  end

  assign main_v      = (state_q != EMPTY);
  assign skid_v      = (state_q == FULL);
  assign in_ready    = ~skid_v;
  assign out_valid   = main_v;
  assign out_data    = main_d;
  assign out_sel_err = main_e;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = main_v & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        unique case ({in_fire, out_fire})
          2'b10: begin
            state_d = FULL;
            ld_skid = 1'b1;
          end
          2'b01: state_d = EMPTY;
          2'b11: ld_main_in = 1'b1;
          default: ;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          state_d      = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Main (output) register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_d <= '0;
      main_e <= 1'b0;
    end else if (ld_main_in) begin
      main_d <= sel_val;
      main_e <= sel_err;
    end else if (ld_main_skid) begin
      main_d <= skid_d;
      main_e <= skid_e;
    end
  end

  // Skid register; cleared once its entry moves to main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_d <= '0;
      skid_e <= 1'b0;
    end else if (ld_skid) begin
      skid_d <= sel_val;
      skid_e <= sel_err;
    end else if (ld_main_skid) begin
      skid_d <= '0;
      skid_e <= 1'b0;
    end
  end

  // Saturating count of accepted illegal selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (in_fire && sel_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_n_bit_mux_sel_pipe.sv
// Directed bench for n_bit_mux_sel_pipe.
// Two instances: full 8-way mux and 5-way mux with 2-bit error counter.
module tb_n_bit_mux_sel_pipe;

  logic clk;

  logic         a_rst_n;
  logic [255:0] a_in_data;
  logic [2:0]   a_in_sel;
  logic         a_in_valid;
  logic         a_in_ready;
  logic [31:0]  a_out_data;
  logic         a_out_sel_err;
  logic         a_out_valid;
  logic         a_out_ready;
  logic [7:0]   a_err_count;

  logic         b_rst_n;
  logic [159:0] b_in_data;
  logic [2:0]   b_in_sel;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [31:0]  b_out_data;
  logic         b_out_sel_err;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [1:0]   b_err_count;

  int n_chk;
  int n_pass;

  n_bit_mux_sel_pipe #(.N(32), .M(8), .SEL_W(3), .CNT_W(8)) u_a (
    .clk         (clk),
    .rst_n       (a_rst_n),
    .in_data     (a_in_data),
    .in_sel      (a_in_sel),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .out_data    (a_out_data),
    .out_sel_err (a_out_sel_err),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .err_count   (a_err_count)
  );

  n_bit_mux_sel_pipe #(.N(32), .M(5), .SEL_W(3), .CNT_W(2)) u_b (
    .clk         (clk),
    .rst_n       (b_rst_n),
    .in_data     (b_in_data),
    .in_sel      (b_in_sel),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .out_data    (b_out_data),
    .out_sel_err (b_out_sel_err),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .err_count   (b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] dat [8];
    logic [31:0] q [$];
    logic [31:0] held;
    logic [1:0]  sat_exp [6];
    logic        stalled;

    n_chk = 0;
    n_pass = 0;
    a_rst_n = 1'b0;  b_rst_n = 1'b0;
    a_in_data = '0;  b_in_data = '0;
    a_in_sel = '0;   b_in_sel = '0;
    a_in_valid = 0;  b_in_valid = 0;
    a_out_ready = 0; b_out_ready = 0;
    repeat (2) tick();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_ready", a_in_ready, 1'b1);
    chk("rst_data", a_out_data, 32'h0);
    chk("rst_err", a_out_sel_err, 1'b0);
    chk("rst_cnt", a_err_count, 8'd0);
    chk("rst_cnt_b", b_err_count, 2'd0);

    // Sweep all selects back-to-back.
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'hA000_0000 + k;
    a_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_in_sel = 3'(k);
      a_in_valid = 1'b1;
      tick();
      chk("sweep_valid", a_out_valid, 1'b1);
      chk("sweep_data", a_out_data, 32'hA000_0000 + k);
      chk("sweep_serr", a_out_sel_err, 1'b0);
    end
    a_in_valid = 1'b0;
    tick();
    chk("sweep_drain", a_out_valid, 1'b0);
    chk("sweep_cnt", a_err_count, 8'd0);

    // Illegal selects on the 5-way mux.
    for (int k = 0; k < 5; k++) b_in_data[k*32 +: 32] = 32'hB000_0000 + k;
    b_out_ready = 1'b1;
    for (int s = 5; s < 8; s++) begin
      b_in_sel = 3'(s);
      b_in_valid = 1'b1;
      tick();
      chk("ill_valid", b_out_valid, 1'b1);
      chk("ill_data", b_out_data, 32'h0);
      chk("ill_serr", b_out_sel_err, 1'b1);
    end
    b_in_sel = 3'd2;
    tick();
    chk("leg_data", b_out_data, 32'hB000_0002);
    chk("leg_serr", b_out_sel_err, 1'b0);
    chk("ill_cnt", b_err_count, 2'd3);
    b_in_valid = 1'b0;
    tick();

    // Counter saturation.
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    chk("sat_rst", b_err_count, 2'd0);
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      b_in_sel = 3'(5 + (i % 3));
      b_in_valid = 1'b1;
      tick();
      chk("sat_cnt", b_err_count, sat_exp[i]);
    end
    b_in_valid = 1'b0;
    tick();

    // Backpressure with skid.
    a_in_sel = 3'd0;
    a_in_valid = 1'b1;
    a_in_data[31:0] = 32'd1;
    tick();
    chk("bp_v1", a_out_valid, 1'b1);
    chk("bp_d1", a_out_data, 32'd1);
    a_out_ready = 1'b0;
    a_in_data[31:0] = 32'd2;
    tick();
    chk("bp_full_rdy", a_in_ready, 1'b0);
    chk("bp_hold1", a_out_data, 32'd1);
    a_in_data[31:0] = 32'd3;
    tick();
    chk("bp_stall_rdy", a_in_ready, 1'b0);
    chk("bp_hold1b", a_out_data, 32'd1);
    a_out_ready = 1'b1;
    tick();
    chk("bp_d2", a_out_data, 32'd2);
    chk("bp_rdy_back", a_in_ready, 1'b1);
    tick();
    chk("bp_d3", a_out_data, 32'd3);
    a_in_data[31:0] = 32'd4;
    tick();
    chk("bp_d4", a_out_data, 32'd4);
    a_in_valid = 1'b0;
    tick();
    chk("bp_empty", a_out_valid, 1'b0);

    // Asynchronous reset while FULL.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_in_sel = 3'd1;
    tick();
    b_in_sel = 3'd3;
    tick();
    chk("mid_full", b_in_ready, 1'b0);
    #3;
    b_rst_n = 1'b0;
    #1;
    chk("mid_valid", b_out_valid, 1'b0);
    chk("mid_ready", b_in_ready, 1'b1);
    chk("mid_cnt", b_err_count, 2'd0);
    chk("mid_data", b_out_data, 32'h0);
    b_in_valid = 1'b0;
    tick();
    b_rst_n = 1'b1;
    b_out_ready = 1'b1;
    b_in_valid = 1'b1;
    b_in_sel = 3'd4;
    tick();
    chk("post_data", b_out_data, 32'hB000_0004);
    chk("post_valid", b_out_valid, 1'b1);
    b_in_valid = 1'b0;
    tick();
    chk("post_alone", b_out_valid, 1'b0);

    // Random traffic against a reference queue.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 8; k++) begin
        dat[k] = $urandom;
        a_in_data[k*32 +: 32] = dat[k];
      end
      a_in_sel = 3'($urandom_range(0, 7));
      a_in_valid = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) chk("rnd_underflow", 1'b1, 1'b0);
        else chk("rnd_order", a_out_data, q.pop_front());
      end
      if (a_in_valid && a_in_ready) q.push_back(dat[a_in_sel]);
      stalled = a_out_valid && !a_out_ready;
      held = a_out_data;
      tick();
      if (stalled) chk("rnd_hold", a_out_data, held);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
